// File: rtl/channel_rr_arbiter.sv
// Round-robin merge of NumIn valid/ack word channels into one registered output slot.
// A grant may be held for up to MaxBurst consecutive words while other channels wait.
module channel_rr_arbiter #(
  parameter int N        = 8,
  parameter int NumIn    = 4,
  parameter int MaxBurst = 4,
  localparam int TW      = $clog2(NumIn)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NumIn*N-1:0] in_d,
  input  logic [NumIn-1:0]   in_v,
  output logic [NumIn-1:0]   in_a,
  output logic [N-1:0]       out_d,
  output logic               out_v,
  input  logic               out_a,
  output logic [TW-1:0]      out_tag
);

  localparam int BW = $clog2(MaxBurst + 1);

  logic [TW-1:0] ptr;
  logic [TW-1:0] cur;
  logic [TW-1:0] g;
  logic [BW-1:0] burst_cnt;
  logic          slot_open;
  logic          load;
  logic          cont;

  assign slot_open = !out_v || out_a;
  assign load      = slot_open && (|in_v);

  // Continuation beats the rotating scan; the scan starts just past the last winner.
  always_comb begin
    int  idx;
    logic found;
    cont  = in_v[cur] && (burst_cnt != '0) && (burst_cnt < BW'(MaxBurst));
    g     = cur;
    found = 1'b0;
    idx   = 0;
    if (!cont) begin
      for (int k = 1; k <= NumIn; k++) begin
        idx = (int'(ptr) + k) % NumIn;
        if (!found && in_v[TW'(idx)]) begin
          found = 1'b1;
          g     = TW'(idx);
        end
      end
    end
  end

  always_comb begin
    in_a = '0;
    if (load && !reset) in_a[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v     <= 1'b0;
      out_d     <= '0;
      out_tag   <= '0;
      ptr       <= TW'(NumIn - 1);
      cur       <= '0;
      burst_cnt <= '0;
    end else if (slot_open) begin
      if (load) begin
        out_d     <= in_d[int'(g)*N +: N];
        out_tag   <= g;
        out_v     <= 1'b1;
        cur       <= g;
        ptr       <= g;
        burst_cnt <= cont ? burst_cnt + 1'b1 : BW'(1);
      end else begin
        out_v     <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Directed table plus hand sequences and a scoreboard soak for channel_rr_arbiter
// (instance a: NumIn=3 MaxBurst=2, instance b: NumIn=3 MaxBurst=1).
module tb_channel_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] da;
  logic [2:0]  va, vb;
  logic        aa, ab;
  logic [2:0]  ia, ib;
  logic [7:0]  oda, odb;
  logic        ova, ovb;
  logic [1:0]  ota, otb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  channel_rr_arbiter #(.N(8), .NumIn(3), .MaxBurst(2)) dut_a (
    .clk(clk), .reset(reset), .in_d(da), .in_v(va), .in_a(ia),
    .out_d(oda), .out_v(ova), .out_a(aa), .out_tag(ota)
  );

  channel_rr_arbiter #(.N(8), .NumIn(3), .MaxBurst(1)) dut_b (
    .clk(clk), .reset(reset), .in_d(da), .in_v(vb), .in_a(ib),
    .out_d(odb), .out_v(ovb), .out_a(ab), .out_tag(otb)
  );

  typedef struct packed {
    logic [2:0] v;
    logic       a;
    logic [2:0] ea;
    logic       eov;
    logic [1:0] etag;
  } vec_t;

  localparam int NV = 26;
  localparam logic [23:0] FIXED_D = {8'h3C, 8'hA5, 8'h11};

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fixed_word(input logic [1:0] t);
    logic [23:0] w;
    w = FIXED_D;
    return w[int'(t)*8 +: 8];
  endfunction

  // soak state
  logic [2:0] sv;
  logic [7:0] word [3];
  int sent [3], rcvd [3], seqn [3], wait_cnt [3];
  int maxw;

  task automatic soak_cycle(input bit allow_new);
    logic [2:0] acked;
    int t;
    for (int i = 0; i < 3; i++) begin
      if (allow_new && !sv[i] && $urandom_range(0, 2) != 0) begin
        sv[i]   = 1'b1;
        word[i] = {2'(i), 6'(seqn[i])};
      end
    end
    va = sv;
    da = {word[2], word[1], word[0]};
    aa = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (ova && aa) begin
      check("sb_tag_range", {31'd0, ota < 2'd3}, 32'd1);
      t = int'(ota);
      if (t < 3) begin
        check("sb_word", {24'd0, oda}, {24'd0, 2'(t), 6'(rcvd[t])});
        rcvd[t]++;
      end
    end
    check("in_a_onehot", {31'd0, $countones(ia) <= 1}, 32'd1);
    acked = ia;
    for (int i = 0; i < 3; i++) begin
      if (acked[i]) begin
        sent[i]++;
        seqn[i]++;
        wait_cnt[i] = 0;
      end else if (sv[i] && (|acked)) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
      end
    end
    @(posedge clk); #1;
    sv = sv & ~acked;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k].v = 3'b111; vecs[k].a = 1'b1; vecs[k].eov = 1'b1;
    end
    vecs[0].ea = 3'b001; vecs[0].etag = 2'd0;
    vecs[1].ea = 3'b001; vecs[1].etag = 2'd0;
    vecs[2].ea = 3'b010; vecs[2].etag = 2'd1;
    vecs[3].ea = 3'b010; vecs[3].etag = 2'd1;
    vecs[4].ea = 3'b100; vecs[4].etag = 2'd2;
    vecs[5].ea = 3'b100; vecs[5].etag = 2'd2;
    vecs[6].ea = 3'b001; vecs[6].etag = 2'd0;
    vecs[7].ea = 3'b001; vecs[7].etag = 2'd0;
    vecs[8] = '{v: 3'b111, a: 1'b1, ea: 3'b010, eov: 1'b1, etag: 2'd1};
    for (int k = 9; k < 13; k++)
      vecs[k] = '{v: 3'b111, a: 1'b0, ea: 3'b000, eov: 1'b1, etag: 2'd1};
    vecs[13] = '{v: 3'b111, a: 1'b1, ea: 3'b010, eov: 1'b1, etag: 2'd1};
    vecs[14] = '{v: 3'b111, a: 1'b1, ea: 3'b100, eov: 1'b1, etag: 2'd2};
    vecs[15] = '{v: 3'b000, a: 1'b1, ea: 3'b000, eov: 1'b0, etag: 2'd2};
    for (int k = 16; k < 26; k++)
      vecs[k] = '{v: 3'b010, a: 1'b1, ea: 3'b010, eov: 1'b1, etag: 2'd1};

    // reset with everyone requesting
    reset = 1'b1; da = FIXED_D; va = 3'b111; aa = 1'b1; vb = 3'b000; ab = 1'b1;
    #2;
    check("rst_in_a", {29'd0, ia}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_out_v", {31'd0, ova}, 32'd0);
      check("rst_out_tag", {30'd0, ota}, 32'd0);
      check("rst_out_d", {24'd0, oda}, 32'd0);
      check("rst_in_a", {29'd0, ia}, 32'd0);
    end
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      va = vecs[k].v; aa = vecs[k].a;
      #1;
      check($sformatf("vec%0d_in_a", k), {29'd0, ia}, {29'd0, vecs[k].ea});
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_v", k), {31'd0, ova}, {31'd0, vecs[k].eov});
      check($sformatf("vec%0d_out_tag", k), {30'd0, ota}, {30'd0, vecs[k].etag});
      if (vecs[k].eov)
        check($sformatf("vec%0d_out_d", k), {24'd0, oda}, {24'd0, fixed_word(vecs[k].etag)});
    end

    // input 0 takes one word, then drops; input 2 is next with a fresh burst
    va = 3'b001; aa = 1'b1; #1;
    check("drop_in_a0", {29'd0, ia}, 32'b001);
    @(posedge clk); #1;
    check("drop_tag0", {30'd0, ota}, 32'd0);
    va = 3'b100; #1;
    check("drop_in_a2", {29'd0, ia}, 32'b100);
    @(posedge clk); #1;
    check("drop_tag2", {30'd0, ota}, 32'd2);
    check("drop_burst_cnt", {30'd0, dut_a.burst_cnt}, 32'd1);

    // async reset while stalled with a word held
    va = 3'b000; aa = 1'b0;
    @(posedge clk); #1;
    check("stall_out_v", {31'd0, ova}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out_v", {31'd0, ova}, 32'd0);
    check("async_rst_tag", {30'd0, ota}, 32'd0);
    #2 reset = 1'b0;
    va = 3'b110; aa = 1'b1; #1;
    check("post_rst_in_a", {29'd0, ia}, 32'b010);
    @(posedge clk); #1;
    check("post_rst_tag", {30'd0, ota}, 32'd1);
    check("post_rst_out_d", {24'd0, oda}, 32'hA5);
    va = 3'b000;
    @(posedge clk); #1;

    // pure round robin on instance b
    vb = 3'b111; ab = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr1_%0d_in_a", k), {29'd0, ib}, 32'(1 << (k % 3)));
      @(posedge clk); #1;
      check($sformatf("rr1_%0d_tag", k), {30'd0, otb}, 32'(k % 3));
      check($sformatf("rr1_%0d_out_v", k), {31'd0, ovb}, 32'd1);
    end
    vb = 3'b000;
    @(posedge clk); #1;

    // scoreboard soak on instance a with random sources and sink
    sv = '0; maxw = 0;
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0; rcvd[i] = 0; seqn[i] = 0; wait_cnt[i] = 0; word[i] = '0;
    end
    for (int c = 0; c < 2000; c++) soak_cycle(1'b1);
    for (int c = 0; c < 100 && (sv != 3'b000 || ova); c++) soak_cycle(1'b0);
    check("drain_done", {31'd0, (sv == 3'b000) && !ova}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("delivered_%0d", i), 32'(rcvd[i]), 32'(sent[i]));
      check($sformatf("sent_nonzero_%0d", i), {31'd0, sent[i] > 0}, 32'd1);
    end
    check("fair_max_wait", {31'd0, maxw <= 4}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
